// File: rtl/evm_control_unit.sv
// rtl/evm_control_unit.sv - control core of a 4-candidate electronic voting machine
//
// Purpose: enforces one vote per 6-bit voter ID through a 64-bit voted-UID bitmap.
// Keeps per-candidate and total tallies, echoes the last accepted vote (VVPAT),
// drives status LEDs, and in result mode reports a candidate count and the winner.
//
// Optional feature: define EVM_TIE_FLAG_EN to report ties on the maximum
// non-zero count as result=3'b111. Without it, ties resolve to the lowest index.
//
// Ports:
//   clock                 in   rising-edge system clock
//   reset                 in   synchronous, active-high
//   c1..c4                in   candidate buttons
//   mode                  in   1 = voting, 0 = result
//   UID                   in   6-bit voter ID
//   enter                 in   cast/confirm key (level)
//   led                   out  [0] accept pulse, [1] duplicate, [2] bad buttons,
//                              [3] voting mode, [7:4] one-hot last accepted candidate
//   votecount             out  result mode: selected candidate count, saturated to 15
//   result                out  result mode: winner code (0 = no votes)
//   totalvotes            out  accepted votes
//   vvpat_votedfor        out  last accepted candidate number 1..4
//   e_total_votes_casted  out  qualified attempts (rising edges of req)
//   count                 out  voted-UID bitmap
module evm_control_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             c1,
  input  logic             c2,
  input  logic             c3,
  input  logic             c4,
  input  logic             mode,
  input  logic [5:0]       UID,
  input  logic             enter,
  output logic [7:0]       led,
  output logic [3:0]       votecount,
  output logic [2:0]       result,
  output logic [CNT_W-1:0] totalvotes,
  output logic [7:0]       vvpat_votedfor,
  output logic [CNT_W-1:0] e_total_votes_casted,
  output logic [63:0]      count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] VC_MAX  = CNT_W'(15);

  logic [CNT_W-1:0] cand_cnt [4];
  logic             req_q;

  logic [3:0]       btn;
  logic             sel_one;
  logic [1:0]       sel_idx;
  logic             req;
  logic             already;
  logic [CNT_W-1:0] sel_cnt;

  logic [1:0]       best_idx;
  logic [CNT_W-1:0] best_cnt;
  logic             tie;
  logic [2:0]       winner;

  assign btn     = {c4, c3, c2, c1};
  assign req     = mode & enter & sel_one;
  assign already = count[UID];
  assign sel_cnt = cand_cnt[sel_idx];

  always_comb begin
    sel_one = 1'b1;
    sel_idx = 2'd0;
    case (btn)
      4'b0001: sel_idx = 2'd0;
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_one = 1'b0;
    endcase
  end

  // Strict '>' keeps the lowest index on equal counts; tie is only raised
  // for equality on the running maximum and is cleared when a larger count appears.
  always_comb begin
    best_idx = 2'd0;
    best_cnt = cand_cnt[0];
    tie      = 1'b0;
    for (int i = 1; i < 4; i++) begin
      if (cand_cnt[i] > best_cnt) begin
        best_cnt = cand_cnt[i];
        best_idx = i[1:0];
        tie      = 1'b0;
      end else if ((cand_cnt[i] == best_cnt) && (best_cnt != '0)) begin
        tie = 1'b1;
      end
    end
  end

`ifdef EVM_TIE_FLAG_EN
  assign winner = tie ? 3'b111 : ({1'b0, best_idx} + 3'd1);
`else
  assign winner = {1'b0, best_idx} + 3'd1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cand_cnt[i] <= '0;
      totalvotes           <= '0;
      e_total_votes_casted <= '0;
      count                <= '0;
      vvpat_votedfor       <= '0;
      led                  <= '0;
      votecount            <= '0;
      result               <= '0;
      req_q                <= 1'b0;
    end else begin
      req_q  <= req;
      led[3] <= mode;
      led[0] <= 1'b0;

      if (req && !req_q && (e_total_votes_casted != CNT_MAX))
        e_total_votes_casted <= e_total_votes_casted + CNT_W'(1);

      if (req && !already) begin
        if (cand_cnt[sel_idx] != CNT_MAX)
          cand_cnt[sel_idx] <= cand_cnt[sel_idx] + CNT_W'(1);
        if (totalvotes != CNT_MAX)
          totalvotes <= totalvotes + CNT_W'(1);
        count[UID]     <= 1'b1;
        vvpat_votedfor <= {6'd0, sel_idx} + 8'd1;
        led[7:4]       <= 4'b0001 << sel_idx;
        led[0]         <= 1'b1;
      end

      // Error flags latch while enter is held and drop as soon as it is released.
      if (!enter || !mode) begin
        led[1] <= 1'b0;
        led[2] <= 1'b0;
      end else begin
        if (req && already) led[1] <= 1'b1;
        if (!sel_one)       led[2] <= 1'b1;
      end

      if (mode) begin
        votecount <= '0;
        result    <= '0;
      end else begin
        if (!sel_one)            votecount <= '0;
        else if (sel_cnt > VC_MAX) votecount <= 4'hF;
        else                     votecount <= sel_cnt[3:0];
        result <= (totalvotes == '0) ? 3'd0 : winner;
      end
    end
  end

endmodule

// File: tb/tb_evm_control_unit.sv
// tb/tb_evm_control_unit.sv - directed self-checking bench for evm_control_unit
module tb_evm_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        c1 = 1'b0, c2 = 1'b0, c3 = 1'b0, c4 = 1'b0;
  logic        mode = 1'b0;
  logic [5:0]  UID = 6'd0;
  logic        enter = 1'b0;
  logic [7:0]  led;
  logic [3:0]  votecount;
  logic [2:0]  result;
  logic [7:0]  totalvotes;
  logic [7:0]  vvpat_votedfor;
  logic [7:0]  e_total_votes_casted;
  logic [63:0] count;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_map = 64'h0;

  evm_control_unit #(.CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .mode(mode), .UID(UID), .enter(enter),
    .led(led), .votecount(votecount), .result(result),
    .totalvotes(totalvotes), .vvpat_votedfor(vvpat_votedfor),
    .e_total_votes_casted(e_total_votes_casted), .count(count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int cand);
    c1 = (cand == 1); c2 = (cand == 2); c3 = (cand == 3); c4 = (cand == 4);
  endtask

  task automatic do_reset();
    reset = 1'b1; mode = 1'b0; enter = 1'b0; press(0);
    tick();
    reset = 1'b0;
    exp_map = 64'h0;
  endtask

  // One vote: hold enter for one edge, check accept/reject, then release.
  task automatic vote(input logic [5:0] uid, input int cand, input bit accept);
    mode = 1'b1; UID = uid; press(cand); enter = 1'b1;
    tick();
    chk("vote_led0", led[0], accept);
    chk("vote_led1", led[1], !accept);
    if (accept) begin
      exp_map[uid] = 1'b1;
      chk("vote_vvpat", vvpat_votedfor, cand);
      chk("vote_led74", led[7:4], 4'b0001 << (cand - 1));
    end
    chk("vote_map", count, exp_map);
    enter = 1'b0; press(0);
    tick();
    chk("release_led12", led[2:1], 2'b00);
  endtask

  task automatic show(input int cand, input logic [3:0] exp_vc, input logic [2:0] exp_res);
    mode = 1'b0; enter = 1'b0; press(cand);
    tick();
    chk("res_votecount", votecount, exp_vc);
    chk("res_result", result, exp_res);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_led", led, 8'h00);
    chk("rst_votecount", votecount, 4'd0);
    chk("rst_result", result, 3'd0);
    chk("rst_total", totalvotes, 8'd0);
    chk("rst_vvpat", vvpat_votedfor, 8'd0);
    chk("rst_attempts", e_total_votes_casted, 8'd0);
    chk("rst_count", count, 64'h0);

    // Enter with no button, then add c1 while enter stays high
    mode = 1'b1; UID = 6'h02; enter = 1'b1; press(0);
    tick();
    chk("nobtn_led2", led[2], 1'b1);
    chk("nobtn_led3", led[3], 1'b1);
    chk("nobtn_total", totalvotes, 8'd0);
    press(1);
    tick();
    exp_map[2] = 1'b1;
    chk("first_led0", led[0], 1'b1);
    chk("first_led74", led[7:4], 4'b0001);
    chk("first_total", totalvotes, 8'd1);
    chk("first_vvpat", vvpat_votedfor, 8'd1);
    chk("first_map", count, exp_map);
    chk("first_attempts", e_total_votes_casted, 8'd1);
    tick();
    chk("hold_led0", led[0], 1'b0);
    chk("hold_led1", led[1], 1'b1);
    chk("hold_total", totalvotes, 8'd1);
    chk("hold_attempts", e_total_votes_casted, 8'd1);
    enter = 1'b0; press(0);
    tick();
    chk("drop_led12", led[2:1], 2'b00);

    // Vote sequence with one duplicate UID
    vote(6'h11, 2, 1'b1);
    vote(6'h13, 3, 1'b1);
    vote(6'h15, 2, 1'b1);
    vote(6'h3C, 4, 1'b1);
    vote(6'h21, 1, 1'b1);
    vote(6'h3C, 1, 1'b0);
    vote(6'h31, 1, 1'b1);
    vote(6'h38, 4, 1'b1);
    vote(6'h2A, 1, 1'b1);
    chk("seq_total", totalvotes, 8'd9);
    chk("seq_attempts", e_total_votes_casted, 8'd10);
    chk("seq_vvpat", vvpat_votedfor, 8'd1);

    // Result mode readout
    show(1, 4'd4, 3'd1);
    chk("res_led3", led[3], 1'b0);
    show(2, 4'd2, 3'd1);
    show(3, 4'd1, 3'd1);
    show(4, 4'd2, 3'd1);
    show(0, 4'd0, 3'd1);
    mode = 1'b0; c1 = 1'b1; c3 = 1'b1;
    tick();
    chk("res_multi_votecount", votecount, 4'd0);

    // Enter in result mode with an unused UID changes nothing
    mode = 1'b0; enter = 1'b1; press(1); UID = 6'h05;
    tick(); tick();
    chk("frozen_total", totalvotes, 8'd9);
    chk("frozen_map", count, exp_map);
    chk("frozen_attempts", e_total_votes_casted, 8'd10);
    chk("frozen_led0", led[0], 1'b0);
    chk("frozen_votecount", votecount, 4'd4);
    enter = 1'b0; press(0);

    // Reset mid-operation, then a two-way tie at 3 votes
    mode = 1'b1; UID = 6'h07; press(2); enter = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0; enter = 1'b0; press(0); mode = 1'b0;
    exp_map = 64'h0;
    chk("midrst_total", totalvotes, 8'd0);
    chk("midrst_map", count, 64'h0);
    show(1, 4'd0, 3'd0);
    vote(6'h00, 2, 1'b1);
    vote(6'h01, 3, 1'b1);
    vote(6'h02, 2, 1'b1);
    vote(6'h03, 3, 1'b1);
    vote(6'h04, 2, 1'b1);
    vote(6'h05, 3, 1'b1);
`ifdef EVM_TIE_FLAG_EN
    show(2, 4'd3, 3'b111);
    show(3, 4'd3, 3'b111);
`else
    show(2, 4'd3, 3'd2);
    show(3, 4'd3, 3'd2);
`endif
    chk("tie_total", totalvotes, 8'd6);

    // votecount saturates at 15
    do_reset();
    for (int i = 0; i < 16; i++) vote(6'(10 + i), 1, 1'b1);
    chk("sat_total", totalvotes, 8'd16);
    show(1, 4'd15, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/evm_control_unit.md
Name: evm_control_unit

Overview:
Control core of a 4-candidate electronic voting machine. It takes a 6-bit voter ID (UID), four candidate buttons and an enter key, and enforces one vote per UID with a 64-bit voted-UID bitmap. It keeps per-candidate and total tallies, a VVPAT echo of the last accepted vote, and status LEDs. In result mode it reports a selected candidate's count and the winner. It sits between the keypad/ID front end and the display logic.

Parameters:
CNT_W, 8, width of the per-candidate and total counters; all counters saturate at 2^CNT_W-1.

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  synchronous, active-high
c1  in  1  candidate 1 button
c2  in  1  candidate 2 button
c3  in  1  candidate 3 button
c4  in  1  candidate 4 button
mode  in  1  1 = voting mode, 0 = result mode
UID  in  6  voter ID
enter  in  1  cast/confirm key, level
led  out  8  status: [0] vote accepted (1-cycle pulse), [1] duplicate UID rejected, [2] invalid button pattern, [3] voting mode, [7:4] one-hot last accepted candidate
votecount  out  4  result mode: count of the selected candidate
result  out  3  result mode: winner code
totalvotes  out  8  accepted votes
vvpat_votedfor  out  8  last accepted candidate number, 1..4
e_total_votes_casted  out  8  qualified attempts, including rejected duplicates
count  out  64  voted-UID bitmap; bit n set means UID n has voted

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset clears all counters, the bitmap, led, votecount, result and vvpat_votedfor to 0.
- sel_one = exactly one of c1..c4 is high.
- req = mode & enter & sel_one.
- Voting mode (mode=1), on each clock edge:
  - req & !count[UID]: increment that candidate's counter and totalvotes; set count[UID]; load vvpat_votedfor with the candidate number; set led[7:4] one-hot to that candidate; pulse led[0] for one cycle.
  - req & count[UID]: no tally change; led[1]=1.
  - enter & !sel_one: no tally change; led[2]=1.
  - led[1] and led[2] are level flags. They clear when enter=0.
  - Holding enter for many cycles yields at most one accepted vote per UID, because the bitmap blocks repeats.
  - e_total_votes_casted increments on each 0->1 transition of req. A change of UID or button while enter stays high, with the result still qualifying, counts as a new attempt only if req dropped in between.
  - votecount=0 and result=0 in voting mode.
- Result mode (mode=0):
  - Voting is disabled; tallies and bitmap are frozen.
  - votecount = count of the candidate whose button is high, saturated to 15.
  - votecount=0 when no button or more than one button is high.
  - result = index (1..4) of the candidate with the highest count.
  - result=0 when totalvotes=0.
  - Ties are handled per EVM_TIE_FLAG_EN.
  - Outputs update one cycle after the inputs change.
- Mode switching mid-press: the mode sampled on the current edge governs.
- Saturation: counters hold at max and never wrap.
- Reset mid-operation discards everything on the next edge.

Optional Feature:
Macro EVM_TIE_FLAG_EN.
- Defined: when two or more candidates share the maximum non-zero count, result=3'b111.
- Undefined: ties resolve to the lowest candidate index.

Test Plan:
- Reset asserted for one edge -> all outputs 0, count=64'h0.
- mode=1, UID=0x02, enter=1, no button -> led[2]=1, totalvotes=0. Then c1=1 with enter still high -> candidate 1 count=1, totalvotes=1, vvpat_votedfor=1, count[2]=1, led[0] pulses once, led[7:4]=4'b0001.
- Cast votes: 0x11 c2, 0x13 c3, 0x15 c2, 0x3C c4, 0x21 c1, 0x3C c1, 0x31 c1, 0x38 c4, 0x2A c1, with enter dropped between votes -> second 0x3C attempt rejected (led[1]=1). Final tallies c1=4, c2=2, c3=1, c4=2; totalvotes=9; e_total_votes_casted=10.
- mode=0, then c1, c2, c3, c4 pressed in turn -> votecount 4, 2, 1, 2; result=1.
- Two candidates each given 3 votes, result mode -> result=3'b111 with EVM_TIE_FLAG_EN; lower index without it.
- mode=0, enter=1, c1=1, unused UID -> no tally or bitmap change.
